// File: rtl/fifo_rd_stream.sv
// Read-side drain stage for the async FIFO: issues reads, absorbs the 1-cycle
// read latency and presents words on a valid/ready stream via a 2-entry buffer.
module fifo_rd_stream #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             rclk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             fifo_empty,
    input  logic [DSIZE-1:0] fifo_rdata,
    output logic             fifo_rreq,
    output logic             out_valid,
    output logic [DSIZE-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [DSIZE-1:0] mem_q [2];
    logic             head_q;
    logic             tail_q;
    logic [1:0]       occ_q;
    logic             inflight_q;
    logic [CNT_W-1:0] count_q;

    logic [1:0]       owned_c;
    logic             push_c;
    logic             pop_c;

    // Words owned = buffered + in flight; capped at 2 so a capture always finds a free slot.
    assign owned_c   = occ_q + 2'(inflight_q);
    assign fifo_rreq = (state_q == RUN) & ~fifo_empty & (owned_c < 2'd2);

    assign out_valid = (occ_q != 2'd0);
    assign out_data  = mem_q[head_q];
    assign out_count = count_q;
    assign busy      = out_valid | inflight_q;

    assign pop_c  = out_valid & out_ready;
    assign push_c = inflight_q & ~flush & (state_q != FLUSH);

    // Next-state logic; flush wins over en in every state.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = FLUSH;
        end else begin
            case (state_q)
                IDLE:    state_d = en ? RUN : IDLE;
                RUN:     state_d = en ? RUN : IDLE;
                FLUSH:   state_d = en ? RUN : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output buffer, in-flight tracking and delivered-word counter.
    always_ff @(posedge rclk) begin
        if (rst) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            count_q    <= '0;
        end else begin
            inflight_q <= fifo_rreq;
            if (pop_c) begin
                count_q <= count_q + CNT_W'(1);
            end
            if (flush) begin
                head_q <= 1'b0;
                tail_q <= 1'b0;
                occ_q  <= 2'd0;
            end else begin
                if (push_c) begin
                    mem_q[tail_q] <= fifo_rdata;
                    tail_q        <= ~tail_q;
                end
                if (pop_c) begin
                    head_q <= ~head_q;
                end
                occ_q <= occ_q + 2'(push_c) - 2'(pop_c);
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based FIFO and stream model, directed
// scenarios with literal expectations, then a randomized soak.
module tb_fifo_rd_stream;

    localparam int unsigned DSIZE = 8;
    localparam int unsigned CNT_W = 4;

    logic             rclk = 1'b0;
    logic             rst;
    logic             en;
    logic             flush;
    logic             fifo_empty;
    logic [DSIZE-1:0] fifo_rdata;
    logic             fifo_rreq;
    logic             out_valid;
    logic [DSIZE-1:0] out_data;
    logic             out_ready;
    logic [CNT_W-1:0] out_count;
    logic             busy;

    fifo_rd_stream #(.DSIZE(DSIZE), .CNT_W(CNT_W)) dut (
        .rclk       (rclk),
        .rst        (rst),
        .en         (en),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rreq  (fifo_rreq),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .out_count  (out_count),
        .busy       (busy)
    );

    always #5 rclk = ~rclk;

    // Upstream FIFO contents, model buffer, delivered-word log.
    logic [DSIZE-1:0] fq [$];
    logic [DSIZE-1:0] mq [$];
    logic [DSIZE-1:0] dq [$];
    logic [DSIZE-1:0] m_infw = '0;
    int               m_inf  = 0;
    int               m_st   = 0;   // 0 idle, 1 run, 2 flush
    int               m_cnt  = 0;
    int               rq_seen = 0;
    int               rmode  = 0;   // 0 ready high, 1 alternating, 2 random
    int               n_chk  = 0;
    int               n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic bit m_rreq();
        return (m_st == 1) && !fifo_empty && (mq.size() + m_inf < 2);
    endfunction

    // One clock: compare DUT against the model at negedge, advance model, then
    // the FIFO delivers the popped word in the cycle after the request.
    task automatic step();
        bit er;
        bit ev;
        bit xf;
        @(negedge rclk);
        er = m_rreq();
        ev = (mq.size() != 0);
        chk("rreq", 32'(fifo_rreq), 32'(er));
        chk("rreq_while_empty", 32'(fifo_rreq & fifo_empty), 32'(0));
        chk("valid", 32'(out_valid), 32'(ev));
        if (ev) chk("data", 32'(out_data), 32'(mq[0]));
        chk("count", 32'(out_count), 32'(m_cnt));
        chk("busy", 32'(busy), 32'(ev || (m_inf != 0)));
        if (fifo_rreq) rq_seen++;
        xf = ev && out_ready;
        if (rst) begin
            mq.delete();
            m_inf = 0;
            m_st  = 0;
            m_cnt = 0;
        end else begin
            if (xf) begin
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
                dq.push_back(mq[0]);
            end
            if (flush) begin
                mq.delete();
                m_st = 2;
            end else begin
                if (xf) void'(mq.pop_front());
                if (m_inf != 0 && m_st != 2) mq.push_back(m_infw);
                m_st = en ? 1 : 0;
            end
            m_inf = er ? 1 : 0;
            if (er) m_infw = fq[0];
        end
        @(posedge rclk);
        #1;
        if (er) fifo_rdata = fq.pop_front();
        else fifo_rdata = DSIZE'($urandom);
        fifo_empty = (fq.size() == 0);
    endtask

    task automatic set_ready();
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom);
        endcase
    endtask

    task automatic wr(input int first, input int n);
        for (int i = 0; i < n; i++) fq.push_back(DSIZE'(first + i));
        if (n > 0) fifo_empty = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((fq.size() != 0 || mq.size() != 0 || m_inf != 0) && n < budget) begin
            set_ready();
            step();
            n++;
        end
        if (n >= budget) begin
            n_chk++;
            $display("FAIL drain_timeout: %0d cycles, fifo %0d, buffered %0d", n, fq.size(), mq.size());
        end
        set_ready();
        step();
    endtask

    task automatic chk_seq(input string nm, input int first, input int n);
        chk({nm, "_len"}, 32'(dq.size()), 32'(n));
        for (int i = 0; i < n && i < dq.size(); i++) chk(nm, 32'(dq[i]), 32'(first + i));
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; flush = 1'b0; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        fq.delete();
        fifo_empty = 1'b1;
        dq.delete();
    endtask

    initial begin
        int n;
        rst = 1'b1; en = 1'b0; flush = 1'b0; out_ready = 1'b0;
        fifo_empty = 1'b1; fifo_rdata = '0;
        repeat (2) @(posedge rclk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_count", 32'(out_count), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_rreq", 32'(fifo_rreq), 32'(0));
        chk("rst_data", 32'(out_data), 32'(0));

        // Basic drain with startup latency pinned
        do_reset();
        en = 1'b1; out_ready = 1'b1; rmode = 0;
        step();
        wr(1, 16);
        #1;
        chk("basic_first_rreq", 32'(fifo_rreq), 32'(1));
        step();
        chk("basic_valid_c1", 32'(out_valid), 32'(0));
        step();
        chk("basic_valid_c2", 32'(out_valid), 32'(1));
        chk("basic_data_c2", 32'(out_data), 32'(1));
        drain(200);
        chk_seq("basic_seq", 1, 16);
        chk("basic_count", 32'(out_count), 32'(16 % (1 << CNT_W)));
        chk("basic_busy", 32'(busy), 32'(0));
        chk("basic_rreq_idle", 32'(fifo_rreq), 32'(0));

        // Backpressure: only two words pulled while stalled
        do_reset();
        en = 1'b1;
        step();
        wr(1, 8);
        rq_seen = 0;
        repeat (10) step();
        chk("bp_rreq_pulses", 32'(rq_seen), 32'(2));
        chk("bp_valid", 32'(out_valid), 32'(1));
        chk("bp_data", 32'(out_data), 32'(1));
        rmode = 0;
        drain(200);
        chk_seq("bp_seq", 1, 8);

        // Alternating ready
        do_reset();
        en = 1'b1; rmode = 1;
        step();
        wr(1, 16);
        drain(400);
        chk_seq("tog_seq", 1, 16);
        chk("tog_count", 32'(out_count), 32'(16 % (1 << CNT_W)));

        // Enable dropped in the cycle of the 3rd read request
        do_reset();
        en = 1'b1; out_ready = 1'b1;
        step();
        wr(1, 8);
        n = 0;
        for (int i = 0; i < 50 && n < 3; i++) begin
            if (m_rreq()) begin
                n++;
                if (n == 3) en = 1'b0;
            end
            step();
        end
        rq_seen = 0;
        repeat (20) step();
        chk("gate_no_rreq", 32'(rq_seen), 32'(0));
        chk_seq("gate_seq", 1, 3);
        chk("gate_busy", 32'(busy), 32'(0));
        en = 1'b1; rmode = 0;
        drain(200);
        chk_seq("gate_resume", 1, 8);

        // Flush with one word buffered and one in flight
        do_reset();
        en = 1'b1;
        step();
        wr(1, 8);
        for (int i = 0; i < 20 && !(mq.size() == 1 && m_inf == 1); i++) step();
        chk("fl_pre_valid", 32'(out_valid), 32'(1));
        chk("fl_pre_busy", 32'(busy), 32'(1));
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_valid_after", 32'(out_valid), 32'(0));
        chk("fl_count", 32'(out_count), 32'(0));
        rmode = 0;
        drain(200);
        chk_seq("fl_seq", 3, 6);

        // Reset mid-stream
        do_reset();
        en = 1'b1; out_ready = 1'b1;
        step();
        wr(1, 10);
        repeat (6) step();
        rst = 1'b1;
        step();
        chk("mrst_valid", 32'(out_valid), 32'(0));
        chk("mrst_count", 32'(out_count), 32'(0));
        chk("mrst_busy", 32'(busy), 32'(0));
        chk("mrst_rreq", 32'(fifo_rreq), 32'(0));
        chk("mrst_data", 32'(out_data), 32'(0));
        rst = 1'b0;

        // Counter wrap
        do_reset();
        en = 1'b1; rmode = 0;
        step();
        wr(1, 17);
        drain(300);
        chk("wrap_count", 32'(out_count), 32'(1));

        // Randomized soak
        do_reset();
        rmode = 2;
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(199) == 0);
            flush = ($urandom_range(39) == 0);
            en    = ($urandom_range(9) != 0);
            set_ready();
            if ($urandom_range(2) == 0 && fq.size() < 20) wr(int'($urandom_range(255)), 1);
            step();
        end
        rst = 1'b0; flush = 1'b0; en = 1'b1;
        drain(400);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
